// File: rtl/core_req_bank_sel_pkg.sv
// Shared widths and helpers for the core request bank selector.
// Width helpers take the module parameters so every file derives the same sizes.
package core_req_bank_sel_pkg;

  localparam int PERF_CTR_BITS = 44;

  function automatic int word_addr_width(input int word_size);
    return 32 - $clog2(word_size);
  endfunction

  function automatic int word_select_bits(input int line_size, input int word_size);
    return $clog2(line_size / word_size);
  endfunction

  function automatic int bank_select_bits(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int line_addr_width(input int word_size, input int line_size,
                                         input int num_banks);
    return word_addr_width(word_size) - word_select_bits(line_size, word_size)
           - bank_select_bits(num_banks);
  endfunction

  function automatic int reqs_bits(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + {7'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/core_req_bank_sel.sv
// Combinational crossbar routing core requests onto bank lanes with fixed
// lowest-index priority per bank; the only state is the bank-conflict counter.
module core_req_bank_sel
  import core_req_bank_sel_pkg::*;
#(
  parameter int CACHE_ID          = 0,
  parameter int CACHE_LINE_SIZE   = 64,
  parameter int NUM_BANKS         = 2,
  parameter int NUM_PORTS         = 1,
  parameter int WORD_SIZE         = 4,
  parameter int NUM_REQS          = 4,
  parameter int CORE_TAG_WIDTH    = 10,
  parameter int BANK_ADDR_OFFSET  = 0,
  parameter int SHARED_BANK_READY = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [NUM_REQS-1:0] core_req_valid_i,
  input  logic [NUM_REQS-1:0] core_req_rw_i,
  input  logic [NUM_REQS*word_addr_width(WORD_SIZE)-1:0] core_req_addr_i,
  input  logic [NUM_REQS*WORD_SIZE-1:0] core_req_byteen_i,
  input  logic [NUM_REQS*8*WORD_SIZE-1:0] core_req_data_i,
  input  logic [NUM_REQS*CORE_TAG_WIDTH-1:0] core_req_tag_i,
  output logic [NUM_REQS-1:0] core_req_ready_o,
  output logic [NUM_BANKS-1:0] per_bank_core_req_valid_o,
  output logic [NUM_BANKS-1:0] per_bank_core_req_rw_o,
  output logic [NUM_BANKS*reqs_bits(NUM_REQS)-1:0] per_bank_core_req_tid_o,
  output logic [NUM_BANKS*line_addr_width(WORD_SIZE, CACHE_LINE_SIZE, NUM_BANKS)-1:0]
               per_bank_core_req_addr_o,
  output logic [NUM_BANKS*WORD_SIZE-1:0] per_bank_core_req_byteen_o,
  output logic [NUM_BANKS*8*WORD_SIZE-1:0] per_bank_core_req_data_o,
  output logic [NUM_BANKS*CORE_TAG_WIDTH-1:0] per_bank_core_req_tag_o,
  output logic [NUM_BANKS*NUM_PORTS-1:0] per_bank_core_req_pmask_o,
  output logic [NUM_BANKS*NUM_PORTS*((word_select_bits(CACHE_LINE_SIZE, WORD_SIZE) > 0) ?
               word_select_bits(CACHE_LINE_SIZE, WORD_SIZE) : 1)-1:0] per_bank_core_req_wsel_o,
  input  logic [((SHARED_BANK_READY != 0) ? 1 : NUM_BANKS)-1:0] per_bank_core_req_ready_i,
  output logic [PERF_CTR_BITS-1:0] bank_stalls_o
);

  localparam int WAW   = word_addr_width(WORD_SIZE);
  localparam int WSB   = word_select_bits(CACHE_LINE_SIZE, WORD_SIZE);
  localparam int BSB   = bank_select_bits(NUM_BANKS);
  localparam int LAW   = line_addr_width(WORD_SIZE, CACHE_LINE_SIZE, NUM_BANKS);
  localparam int RB    = reqs_bits(NUM_REQS);
  localparam int WSW   = (WSB > 0) ? WSB : 1;
  localparam int BSW   = (BSB > 0) ? BSB : 1;
  localparam int DW    = 8 * WORD_SIZE;
  localparam int WSELW = NUM_PORTS * WSW;
  localparam logic [WAW-1:0] LOW_MASK = (WAW'(1) << BANK_ADDR_OFFSET) - WAW'(1);

  if (NUM_PORTS != 1 || CACHE_ID < 0) begin : g_bad_cfg
    $error("core_req_bank_sel: NUM_PORTS must be 1 and CACHE_ID non-negative");
  end

  logic [WAW-1:0]      addr_s  [NUM_REQS];
  logic [WAW-1:0]      line_s  [NUM_REQS];
  logic [BSW-1:0]      bank_s  [NUM_REQS];
  logic [WSW-1:0]      wsel_s  [NUM_REQS];
  logic [LAW-1:0]      baddr_s [NUM_REQS];
  logic [NUM_REQS-1:0] blocked_s;
  logic [7:0]          nstall_s;
  logic [PERF_CTR_BITS-1:0] stalls_q, stalls_d;

  for (genvar r = 0; r < NUM_REQS; r++) begin : g_req
    assign addr_s[r] = core_req_addr_i[r*WAW +: WAW];
    assign line_s[r] = addr_s[r] >> WSB;

    if (WSB > 0) begin : g_wsel
      assign wsel_s[r] = addr_s[r][WSW-1:0];
    end else begin : g_no_wsel
      assign wsel_s[r] = WSW'(0);
    end

    // Bank field is cut out of the line address; bits above it slide down.
    if (BSB > 0) begin : g_bank
      assign bank_s[r]  = line_s[r][BANK_ADDR_OFFSET +: BSW];
      assign baddr_s[r] = LAW'((line_s[r] & LOW_MASK)
                          | ((line_s[r] >> (BANK_ADDR_OFFSET + BSB)) << BANK_ADDR_OFFSET));
    end else begin : g_one_bank
      assign bank_s[r]  = BSW'(0);
      assign baddr_s[r] = LAW'(line_s[r]);
    end

    if (SHARED_BANK_READY != 0) begin : g_rdy_shared
      assign core_req_ready_o[r] = per_bank_core_req_ready_i[0] & ~blocked_s[r];
    end else begin : g_rdy_bank
      assign core_req_ready_o[r] = per_bank_core_req_ready_i[bank_s[r]] & ~blocked_s[r];
    end
  end

  // A request is blocked when any lower-index valid request targets its bank.
  always_comb begin
    blocked_s = '0;
    for (int r = 1; r < NUM_REQS; r++) begin
      for (int j = 0; j < r; j++) begin
        blocked_s[r] = blocked_s[r] | (core_req_valid_i[j] & (bank_s[j] == bank_s[r]));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_sel
    logic          hit_s;
    logic [RB-1:0] sel_s;

    // Scan downwards so the lowest matching index is the one that sticks.
    always_comb begin
      hit_s = 1'b0;
      sel_s = '0;
      for (int r = NUM_REQS - 1; r >= 0; r--) begin
        sel_s = (core_req_valid_i[r] && bank_s[r] == BSW'(b)) ? RB'(r) : sel_s;
        hit_s = hit_s | (core_req_valid_i[r] & (bank_s[r] == BSW'(b)));
      end
    end

    assign per_bank_core_req_valid_o[b] = hit_s;
    assign per_bank_core_req_rw_o[b]    = hit_s & core_req_rw_i[sel_s];
    assign per_bank_core_req_tid_o[b*RB +: RB] = hit_s ? sel_s : '0;
    assign per_bank_core_req_addr_o[b*LAW +: LAW] = hit_s ? baddr_s[sel_s] : '0;
    assign per_bank_core_req_byteen_o[b*WORD_SIZE +: WORD_SIZE] =
        hit_s ? core_req_byteen_i[sel_s*WORD_SIZE +: WORD_SIZE] : '0;
    assign per_bank_core_req_data_o[b*DW +: DW] = hit_s ? core_req_data_i[sel_s*DW +: DW] : '0;
    assign per_bank_core_req_tag_o[b*CORE_TAG_WIDTH +: CORE_TAG_WIDTH] =
        hit_s ? core_req_tag_i[sel_s*CORE_TAG_WIDTH +: CORE_TAG_WIDTH] : '0;
    assign per_bank_core_req_pmask_o[b*NUM_PORTS +: NUM_PORTS] = NUM_PORTS'(hit_s);
    assign per_bank_core_req_wsel_o[b*WSELW +: WSELW] = hit_s ? WSELW'(wsel_s[sel_s]) : '0;
  end

  assign nstall_s = popcount(64'(core_req_valid_i & blocked_s));

  // Every valid loser adds one stall, whether or not its bank is ready.
  always_comb begin
    stalls_d = stalls_q + PERF_CTR_BITS'(nstall_s);
  end

  // Conflict counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stalls_q <= '0;
    end else begin
      stalls_q <= stalls_d;
    end
  end

  assign bank_stalls_o = stalls_q;

endmodule

// File: tb/tb_core_req_bank_sel.sv
// Directed-vector bench for core_req_bank_sel: per-bank ready, shared ready and
// offset bank-field instances driven from one request bus.
module tb_core_req_bank_sel;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   valid, rw;
  logic [119:0] addr;
  logic [15:0]  byteen;
  logic [127:0] data;
  logic [39:0]  tag;
  logic [1:0]   rdy_a, rdy_o;
  logic [0:0]   rdy_s;

  logic [1:0]  pbv_a, prw_a, ppm_a, pws_a, pbv_s, prw_s, ppm_s, pws_s, pbv_o, prw_o, ppm_o, pws_o;
  logic [3:0]  ptid_a, ptid_s, ptid_o, crdy_a, crdy_s, crdy_o;
  logic [57:0] padr_a, padr_s, padr_o;
  logic [7:0]  pbe_a, pbe_s, pbe_o;
  logic [63:0] pdat_a, pdat_s, pdat_o;
  logic [19:0] ptag_a, ptag_s, ptag_o;
  logic [43:0] stl_a, stl_s, stl_o;

  int n_vec = 0;
  int n_err = 0;
  logic [43:0] exp_stl;

  core_req_bank_sel #(.CACHE_LINE_SIZE(4), .SHARED_BANK_READY(0), .BANK_ADDR_OFFSET(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .core_req_valid_i(valid), .core_req_rw_i(rw),
    .core_req_addr_i(addr), .core_req_byteen_i(byteen), .core_req_data_i(data),
    .core_req_tag_i(tag), .core_req_ready_o(crdy_a), .per_bank_core_req_valid_o(pbv_a),
    .per_bank_core_req_rw_o(prw_a), .per_bank_core_req_tid_o(ptid_a),
    .per_bank_core_req_addr_o(padr_a), .per_bank_core_req_byteen_o(pbe_a),
    .per_bank_core_req_data_o(pdat_a), .per_bank_core_req_tag_o(ptag_a),
    .per_bank_core_req_pmask_o(ppm_a), .per_bank_core_req_wsel_o(pws_a),
    .per_bank_core_req_ready_i(rdy_a), .bank_stalls_o(stl_a));

  core_req_bank_sel #(.CACHE_LINE_SIZE(4), .SHARED_BANK_READY(1), .BANK_ADDR_OFFSET(0)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .core_req_valid_i(valid), .core_req_rw_i(rw),
    .core_req_addr_i(addr), .core_req_byteen_i(byteen), .core_req_data_i(data),
    .core_req_tag_i(tag), .core_req_ready_o(crdy_s), .per_bank_core_req_valid_o(pbv_s),
    .per_bank_core_req_rw_o(prw_s), .per_bank_core_req_tid_o(ptid_s),
    .per_bank_core_req_addr_o(padr_s), .per_bank_core_req_byteen_o(pbe_s),
    .per_bank_core_req_data_o(pdat_s), .per_bank_core_req_tag_o(ptag_s),
    .per_bank_core_req_pmask_o(ppm_s), .per_bank_core_req_wsel_o(pws_s),
    .per_bank_core_req_ready_i(rdy_s), .bank_stalls_o(stl_s));

  core_req_bank_sel #(.CACHE_LINE_SIZE(4), .SHARED_BANK_READY(0), .BANK_ADDR_OFFSET(8)) dut_o (
    .clk_i(clk), .rst_ni(rst_n), .core_req_valid_i(valid), .core_req_rw_i(rw),
    .core_req_addr_i(addr), .core_req_byteen_i(byteen), .core_req_data_i(data),
    .core_req_tag_i(tag), .core_req_ready_o(crdy_o), .per_bank_core_req_valid_o(pbv_o),
    .per_bank_core_req_rw_o(prw_o), .per_bank_core_req_tid_o(ptid_o),
    .per_bank_core_req_addr_o(padr_o), .per_bank_core_req_byteen_o(pbe_o),
    .per_bank_core_req_data_o(pdat_o), .per_bank_core_req_tag_o(ptag_o),
    .per_bank_core_req_pmask_o(ppm_o), .per_bank_core_req_wsel_o(pws_o),
    .per_bank_core_req_ready_i(rdy_o), .bank_stalls_o(stl_o));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic w, input logic [29:0] a,
                         input logic [31:0] d, input logic [9:0] t);
    valid[r]          = v;
    rw[r]             = w;
    addr[r*30 +: 30]  = a;
    data[r*32 +: 32]  = d;
    tag[r*10 +: 10]   = t;
    byteen[r*4 +: 4]  = 4'(r + 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic conflict_vec();
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 1'b0, 30'(r), 32'hD000_0000 + 32'(r), 10'(9'h100 + r));
  endtask

  initial begin
    valid = 4'd0; rw = 4'd0; addr = '0; byteen = '0; data = '0; tag = '0;
    rdy_a = 2'b11; rdy_s = 1'b1; rdy_o = 2'b11;
    exp_stl = 44'd0;
    #3;
    chk("reset_stalls_a", stl_a, 44'd0);
    chk("reset_stalls_s", stl_s, 44'd0);
    chk("reset_stalls_o", stl_o, 44'd0);
    step(2);
    rst_n = 1'b1;

    conflict_vec();
    #1;
    chk("conf_pbv", pbv_a, 2'b11);
    chk("conf_tid0", ptid_a[1:0], 2'd0);
    chk("conf_tid1", ptid_a[3:2], 2'd1);
    chk("conf_addr0", padr_a[28:0], 29'd0);
    chk("conf_addr1", padr_a[57:29], 29'd0);
    chk("conf_data1", pdat_a[63:32], 32'hD000_0001);
    chk("conf_be1", pbe_a[7:4], 4'd2);
    chk("conf_pmask", ppm_a, 2'b11);
    chk("conf_wsel", pws_a, 2'b00);
    chk("conf_ready", crdy_a, 4'b0011);
    rdy_a = 2'b01;
    rdy_s = 1'b0;
    #1;
    chk("bank_rdy_ready", crdy_a, 4'b0001);
    chk("shared_low_pbv", pbv_s, 2'b11);
    chk("shared_low_ready", crdy_s, 4'b0000);
    rdy_s = 1'b1;
    #1;
    chk("shared_high_ready", crdy_s, 4'b0011);
    rdy_a = 2'b11;
    step(1); exp_stl = exp_stl + 44'd2;
    chk("conf_stalls_1", stl_a, exp_stl);
    step(1); exp_stl = exp_stl + 44'd2;
    chk("conf_stalls_2", stl_a, exp_stl);

    set_req(0, 1'b1, 1'b0, 30'd4, 32'h1111_0000, 10'h011);
    set_req(1, 1'b0, 1'b0, 30'd0, 32'h0, 10'h0);
    set_req(2, 1'b1, 1'b1, 30'd7, 32'hCAFE_0002, 10'h2A5);
    set_req(3, 1'b0, 1'b0, 30'd0, 32'h0, 10'h0);
    #1;
    chk("sparse_pbv", pbv_a, 2'b11);
    chk("sparse_tid0", ptid_a[1:0], 2'd0);
    chk("sparse_tid1", ptid_a[3:2], 2'd2);
    chk("sparse_addr0", padr_a[28:0], 29'd2);
    chk("sparse_addr1", padr_a[57:29], 29'd3);
    chk("sparse_data1", pdat_a[63:32], 32'hCAFE_0002);
    chk("sparse_tag1", ptag_a[19:10], 10'h2A5);
    chk("sparse_rw", prw_a, 2'b10);
    chk("sparse_ready", crdy_a, 4'b0101);
    step(1);
    chk("sparse_stalls", stl_a, exp_stl);

    valid = 4'd0;
    #1;
    chk("idle_pbv", pbv_a, 2'b00);
    chk("idle_fields", {ptid_a, padr_a[57:29], pbe_a}, 64'd0);
    chk("idle_ready", crdy_a, 4'b1111);

    set_req(0, 1'b1, 1'b0, 30'h301, 32'h5, 10'h5);
    #1;
    chk("ofs_pbv_a", pbv_o, 2'b10);
    chk("ofs_addr_a", padr_o[57:29], 29'h101);
    chk("ofs_tid_a", ptid_o, 4'd0);
    set_req(0, 1'b1, 1'b0, 30'h100, 32'h5, 10'h5);
    #1;
    chk("ofs_pbv_b", pbv_o, 2'b10);
    chk("ofs_addr_b", padr_o[57:29], 29'h000);
    set_req(0, 1'b1, 1'b0, 30'h201, 32'h5, 10'h5);
    #1;
    chk("ofs_pbv_c", pbv_o, 2'b01);
    chk("ofs_addr_c", padr_o[28:0], 29'h101);
    step(1);
    chk("single_stalls", stl_a, exp_stl);

    conflict_vec();
    step(2); exp_stl = exp_stl + 44'd4;
    chk("pre_rst_stalls", stl_a, exp_stl);
    #2;
    rst_n = 1'b0;
    #1;
    exp_stl = 44'd0;
    chk("async_rst_stalls", stl_a, exp_stl);
    chk("rst_comb_pbv", pbv_a, 2'b11);
    step(1);
    chk("held_rst_stalls", stl_a, exp_stl);
    rst_n = 1'b1;
    step(1); exp_stl = exp_stl + 44'd2;
    chk("post_rst_stalls", stl_a, exp_stl);

    valid = 4'd0;
    step(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
